// File: rtl/csr_uart_rx.sv
// rtl/csr_uart_rx.sv - CSR-mapped 8N1 UART receiver with byte FIFO and getchar-style read
module csr_uart_rx #(
    parameter logic [11:0] BASE_ADDR = 12'hBC0,
    parameter int          BAUD_DIV  = 868,
    parameter int          FIFO_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        irq
);

    localparam int          DEPTH       = 1 << FIFO_LOG2;
    localparam int          PW          = FIFO_LOG2 + 1;
    localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          rx_s1_q, rs_q, rx_s3_q;
    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic          overrun_q, frame_err_q, overrun_d, frame_err_d;
    logic          sel_q;

    logic fall_edge, stop_done, push_req, empty, full, pop, wr_en, flush, push_ok, overflow;
    logic unused_wdata;

    assign unused_wdata = ^{wdata[31], wdata[28:1]};

    assign fall_edge = rx_s3_q & ~rs_q;
    assign stop_done = (state_q == S_STOP) && (cnt_q == 16'd0);
    assign push_req  = stop_done & rs_q;

    assign empty    = (rd_ptr_q == wr_ptr_q);
    assign full     = (rd_ptr_q[PW-1] != wr_ptr_q[PW-1]) && (rd_ptr_q[PW-2:0] == wr_ptr_q[PW-2:0]);
    assign pop      = sel_q & ~empty;
    assign wr_en    = sel_q && (modify == 3'd1);
    assign flush    = wr_en & wdata[0];
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign push_ok  = push_req & (~full | pop);
    assign overflow = push_req & full & ~pop;

    assign rd_ptr_d = flush ? '0 : rd_ptr_q + {{(PW-1){1'b0}}, pop};
    assign wr_ptr_d = flush ? '0 : wr_ptr_q + {{(PW-1){1'b0}}, push_ok};

    // Set events beat same-cycle clears so no error is silently lost
    assign overrun_d   = (overrun_q & ~(wr_en & wdata[30])) | overflow;
    assign frame_err_d = (frame_err_q & ~(wr_en & wdata[29])) | (stop_done & ~rs_q);

    assign valid = sel_q;
    assign irq   = ~empty;

    // Read data reflects state before any pop/clear happening at the end of this cycle
    always_comb begin
        rdata = 32'd0;
        if (sel_q) begin
            if (empty) rdata = 32'hFFFF_FFFF;
            else       rdata = {1'b0, overrun_q, frame_err_q, 21'd0, mem_q[rd_ptr_q[PW-2:0]]};
        end
    end

    // Two-flop synchroniser plus a third flop for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1_q <= 1'b1;
            rs_q    <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rs_q    <= rx_s1_q;
            rx_s3_q <= rs_q;
        end
    end

    // Frame FSM: centre-samples start, eight data bits LSB first, then stop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall_edge) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_RELOAD;
                    end
                end
                S_START: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (rs_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q   <= S_DATA;
                        cnt_q     <= FULL_RELOAD;
                        bit_idx_q <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        shreg_q <= {rs_q, shreg_q[7:1]};
                        cnt_q   <= FULL_RELOAD;
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                default: begin
                    if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                    else                state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; pointers alone define occupancy so the array needs no reset
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q[PW-2:0]] <= shreg_q;
    end

    // FIFO pointers, sticky flags and the registered CSR select
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            sel_q       <= read && (addr == BASE_ADDR);
        end
    end

endmodule

// File: tb/tb_csr_uart_rx.sv
// tb/tb_csr_uart_rx.sv - scoreboard bench for csr_uart_rx
module tb_csr_uart_rx;

    localparam int          BAUD = 8;
    localparam logic [11:0] BASE = 12'hBC0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  modify = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [11:0] addr = 12'd0;
    logic [31:0] rdata;
    logic        valid;
    logic        rx = 1'b1;
    logic        irq;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] expq [$];

    csr_uart_rx #(.BASE_ADDR(BASE), .BAUD_DIV(BAUD), .FIFO_LOG2(2)) dut (
        .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
        .addr(addr), .rdata(rdata), .valid(valid), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: every valid read response is matched against the expectation queue
    always @(negedge clk) begin
        if (valid) begin
            nvec++;
            if (expq.size() == 0) begin
                nerr++;
                $display("FAIL rdata_unexpected: got %h with no response expected", rdata);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                if (rdata !== e) begin
                    nerr++;
                    $display("FAIL rdata: got %h expected %h", rdata, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    // One-cycle read, optionally followed by a modify=1 write in the select cycle
    task automatic csr_read(input logic [11:0] a, input logic [31:0] exp,
                            input bit do_wr, input logic [31:0] wd);
        read = 1'b1;
        addr = a;
        if (a == BASE) expq.push_back(exp);
        @(negedge clk);
        read = 1'b0;
        if (do_wr) begin
            modify = 3'd1;
            wdata  = wd;
        end
        @(negedge clk);
        modify = 3'd0;
        wdata  = 32'd0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, then EOF
        send_frame(8'h41, 1'b1);
        check("irq_after_rx", {31'd0, irq}, 32'd1);
        csr_read(BASE, 32'h0000_0041, 1'b0, 32'd0);
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        csr_read(BASE, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // Back-to-back burst of reads
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        read = 1'b1;
        addr = BASE;
        expq.push_back(32'h0000_0055);
        expq.push_back(32'h0000_00A3);
        expq.push_back(32'h0000_0000);
        expq.push_back(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        read = 1'b0;
        @(negedge clk);

        // Overrun: six bytes into a four-entry FIFO
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
        for (int i = 1; i <= 4; i++) csr_read(BASE, 32'h4000_0000 | 32'(i), 1'b0, 32'd0);
        csr_read(BASE, 32'hFFFF_FFFF, 1'b1, 32'h4000_0000);
        send_frame(8'h07, 1'b1);
        csr_read(BASE, 32'h0000_0007, 1'b0, 32'd0);

        // Framing error
        send_frame(8'h7E, 1'b0);
        check("irq_frame_err", {31'd0, irq}, 32'd0);
        send_frame(8'h12, 1'b1);
        csr_read(BASE, 32'h2000_0012, 1'b0, 32'd0);
        csr_read(BASE, 32'hFFFF_FFFF, 1'b1, 32'h2000_0000);

        // Short glitch on rx
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("irq_glitch", {31'd0, irq}, 32'd0);
        send_frame(8'h5A, 1'b1);
        csr_read(BASE, 32'h0000_005A, 1'b0, 32'd0);
        csr_read(BASE, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // Flush during a read: read returns head, flush beats pop
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        csr_read(BASE, 32'h0000_0011, 1'b1, 32'h0000_0001);
        check("irq_flush", {31'd0, irq}, 32'd0);
        csr_read(BASE, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // Reset in the middle of data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rx = 1'b0;
        repeat (BAUD / 2) @(negedge clk);
        rstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("irq_after_reset", {31'd0, irq}, 32'd0);
        send_frame(8'h3C, 1'b1);
        csr_read(BASE, 32'h0000_003C, 1'b0, 32'd0);
        csr_read(BASE, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // Address miss leaves the FIFO alone
        send_frame(8'h99, 1'b1);
        read = 1'b1;
        addr = 12'hBC1;
        @(negedge clk);
        read = 1'b0;
        check("miss_valid", {31'd0, valid}, 32'd0);
        check("miss_rdata", rdata, 32'd0);
        @(negedge clk);
        check("miss_irq", {31'd0, irq}, 32'd1);
        csr_read(BASE, 32'h0000_0099, 1'b0, 32'd0);

        repeat (4) @(negedge clk);
        check("pending_expect", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
